// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with done pulse and optional auto-reload
module countdown_timer #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         stop,
  input  logic         tick,
  input  logic         auto_reload,
  output logic [N-1:0] cnt,
  output logic         busy,
  output logic         done,
  output logic         load_ready
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] reload_q, reload_d;
  logic         done_q, done_d;
  logic [N-1:0] start_val;

  // A same-cycle load overrides the held count as the start value.
  assign start_val = load ? load_value : cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          cnt_d    = load_value;
          reload_d = load_value;
        end
        if (start) begin
          if (start_val != '0) state_d = RUN;
          else                 done_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_q > N'(1)) begin
            cnt_d = cnt_q - N'(1);
          end else begin
            // Terminal count; the else also shields against any underflow.
            done_d = 1'b1;
            if (auto_reload && (reload_q != '0)) begin
              cnt_d = reload_q;
            end else begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign cnt        = cnt_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign load_ready = ~busy;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0, auto_reload = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic [7:0] cnt;
  logic       busy, done, load_ready;

  logic       load2 = 1'b0, start2 = 1'b0, stop2 = 1'b0, tick2 = 1'b0, ar2 = 1'b0;
  logic [1:0] lv2 = 2'd0;
  logic [1:0] cnt2;
  logic       busy2, done2, lr2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  countdown_timer #(.N(8)) dut (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .tick(tick), .auto_reload(auto_reload),
    .cnt(cnt), .busy(busy), .done(done), .load_ready(load_ready)
  );

  countdown_timer #(.N(2)) dut2 (
    .clock(clock), .reset(reset), .load(load2), .load_value(lv2),
    .start(start2), .stop(stop2), .tick(tick2), .auto_reload(ar2),
    .cnt(cnt2), .busy(busy2), .done(done2), .load_ready(lr2)
  );

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       sp;
    logic       tk;
    logic       ar;
    logic [7:0] ecnt;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input int ld, input int lv, input int st, input int sp,
                              input int tk, input int ar, input int ecnt,
                              input int ebusy, input int edone);
    vec_t v;
    v.ld = ld[0]; v.lv = lv[7:0]; v.st = st[0]; v.sp = sp[0];
    v.tk = tk[0]; v.ar = ar[0]; v.ecnt = ecnt[7:0]; v.ebusy = ebusy[0]; v.edone = edone[0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int ec, input int eb, input int ed);
    chk({name, " cnt"}, int'(cnt), ec);
    chk({name, " busy"}, int'(busy), eb);
    chk({name, " done"}, int'(done), ed);
    chk({name, " load_ready"}, int'(load_ready), 1 - eb);
  endtask

  task automatic drive(input logic ld, input logic [7:0] lv, input logic st,
                       input logic sp, input logic tk, input logic ar);
    load = ld; load_value = lv; start = st; stop = sp; tick = tk; auto_reload = ar;
  endtask

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // basic countdown, zero-length start, auto-reload, load+start, load ignored in RUN
    vecs[0]  = mk(1, 3, 0, 0, 0, 0, 3, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 1, 0, 3, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 0, 2, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 2, 0, 0, 0, 1, 2, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 1, 1, 2, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, 1, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 1, 1, 2, 1, 1);
    vecs[12] = mk(0, 0, 0, 0, 1, 1, 1, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 1, 1, 2, 1, 1);
    vecs[14] = mk(0, 0, 0, 0, 1, 1, 1, 1, 0);
    vecs[15] = mk(0, 0, 0, 1, 1, 1, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[17] = mk(1, 5, 1, 0, 1, 0, 5, 1, 0);
    vecs[18] = mk(1, 9, 1, 0, 1, 1, 4, 1, 0);
    vecs[19] = mk(0, 0, 0, 0, 1, 1, 3, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 1, 1, 2, 1, 0);
    vecs[21] = mk(0, 0, 0, 0, 1, 1, 1, 1, 0);
    vecs[22] = mk(0, 0, 0, 0, 1, 1, 5, 1, 1);
    vecs[23] = mk(0, 0, 0, 1, 0, 0, 5, 0, 0);

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #5;
    end
    @(negedge clock);
    chk_all("reset held", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step;
    step;
    chk_all("reset released idle", 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].tk, vecs[i].ar);
      step;
      chk_all($sformatf("vec%0d", i), int'(vecs[i].ecnt), int'(vecs[i].ebusy), int'(vecs[i].edone));
    end

    // tick every 3rd clock: done lands 12 clocks after busy rises
    drive(1, 4, 0, 0, 0, 0);
    step;
    drive(0, 0, 1, 0, 0, 0);
    step;
    chk_all("gate start", 4, 1, 0);
    for (int j = 1; j <= 12; j++) begin
      drive(0, 0, 0, 0, (j % 3) == 0, 0);
      step;
      chk_all($sformatf("gate j%0d", j), (j == 12) ? 0 : 4 - j / 3, (j < 12) ? 1 : 0, (j == 12) ? 1 : 0);
    end

    // stop beats tick, even at cnt==1
    drive(1, 1, 1, 0, 0, 0);
    step;
    drive(0, 0, 0, 1, 1, 0);
    step;
    chk_all("stop vs tick", 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    step;
    chk_all("stop after", 1, 0, 0);

    // reset mid-run at cnt==150
    drive(1, 200, 1, 0, 1, 0);
    step;
    chk_all("long start", 200, 1, 0);
    for (int j = 1; j <= 50; j++) begin
      step;
      chk("long no done", int'(done), 0);
    end
    chk_all("long at 150", 150, 1, 0);
    reset = 1'b0;
    #1;
    chk_all("async reset", 0, 0, 0);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step;
    chk_all("post reset", 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    step;
    chk_all("post reset start0", 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    step;
    chk_all("post reset idle", 0, 0, 0);

    // N=2 full-scale countdown without wrap
    load2 = 1'b1; lv2 = 2'd3;
    step;
    chk("n2 load", int'(cnt2), 3);
    load2 = 1'b0; start2 = 1'b1; tick2 = 1'b1;
    step;
    chk("n2 busy", int'(busy2), 1);
    start2 = 1'b0;
    for (int j = 2; j >= 0; j--) begin
      step;
      chk($sformatf("n2 cnt%0d", j), int'(cnt2), j);
    end
    chk("n2 done", int'(done2), 1);
    chk("n2 idle", int'(busy2), 0);
    step;
    chk("n2 no wrap", int'(cnt2), 0);
    chk("n2 done low", int'(done2), 0);
    chk("n2 load_ready", int'(lr2), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
